// File: rtl/apb_completer_regs_if.sv
// APB link between the bridge (master) and a register completer (slave).
interface apb_completer_regs_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [2:0]              pprot;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_completer_regs.sv
// APB completer: byte-strobed register file with programmable wait states,
// region-based pprot checking and protocol-violation reporting via pslverr.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no transfer; waiting for a setup phase
// S_ACCESS | setup captured; checking stability, counting wait states
// S_RESP   | pready high for one cycle with registered prdata/pslverr
module apb_completer_regs #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_STATES = 0
) (
    input logic                 pclk,
    input logic                 preset,
    apb_completer_regs_if.slave apb
);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     strb_q, strb_d;
    logic [2:0]            prot_q, prot_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    // Offset is widened so the range check works even when the offset
    // field is narrower than the register index.
    logic [63:0]      off_ext;
    logic [IDX_W-1:0] idx;
    logic [2:0]       region;
    logic             eval_err;
    logic             take_setup;
    logic             violation;

    assign off_ext  = 64'(addr_q[ADDR_WIDTH-4:2]);
    assign idx      = off_ext[IDX_W-1:0];
    assign region   = addr_q[ADDR_WIDTH-1:ADDR_WIDTH-3];
    assign eval_err = (addr_q[1:0] != 2'b00)
                   || (off_ext >= 64'(NUM_REGS))
                   || ((region & ~prot_q) != 3'b000);

    assign take_setup = (state_q != S_ACCESS) && apb.psel && !apb.penable;
    assign violation  = !apb.psel || (apb.paddr != addr_q) || (apb.pwrite != write_q);

    // Next-state, capture, register-file update and response generation.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        prot_d    = prot_q;
        cnt_d     = cnt_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        regs_d    = regs_q;

        if (take_setup) begin
            addr_d  = apb.paddr;
            write_d = apb.pwrite;
            wdata_d = apb.pwdata;
            strb_d  = apb.pstrb;
            prot_d  = apb.pprot;
            cnt_d   = 4'(WAIT_STATES);
        end

        case (state_q)
            S_IDLE: begin
                if (take_setup) begin
                    state_d = S_ACCESS;
                end else if (apb.psel && apb.penable) begin
                    state_d   = S_RESP;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                end
            end
            S_ACCESS: begin
                if (violation) begin
                    state_d   = S_RESP;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                end else if (!apb.penable) begin
                    state_d = S_ACCESS;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d  = S_RESP;
                    pready_d = 1'b1;
                    if (eval_err) begin
                        pslverr_d = 1'b1;
                    end else if (write_q) begin
                        for (int i = 0; i < STRB_W; i++) begin
                            if (strb_q[i]) begin
                                regs_d[idx][8*i +: 8] = wdata_q[8*i +: 8];
                            end
                        end
                    end else begin
                        prdata_d = regs_q[idx];
                    end
                end
            end
            S_RESP: begin
                state_d = take_setup ? S_ACCESS : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, captured setup and register file, with synchronous reset.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            prot_q    <= '0;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            regs_q    <= '{default: '0};
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            prot_q    <= prot_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            regs_q    <= regs_d;
        end
    end

    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;
    assign apb.prdata  = prdata_q;
endmodule

// File: tb/tb_apb_completer_regs.sv
// Directed bench for apb_completer_regs: one instance with 2 wait states,
// one with 4 wait states for the reset-during-wait scenario.
module tb_apb_completer_regs;
    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        sel = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [2:0]  pprot = '0;
    logic [31:0] rdata_o;
    logic        rdy_o;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 pclk = ~pclk;

    apb_completer_regs_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if2 ();
    apb_completer_regs_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if4 ();

    assign if2.psel    = psel & ~sel;
    assign if4.psel    = psel & sel;
    assign if2.penable = penable;
    assign if4.penable = penable;
    assign if2.pwrite  = pwrite;
    assign if4.pwrite  = pwrite;
    assign if2.paddr   = paddr;
    assign if4.paddr   = paddr;
    assign if2.pwdata  = pwdata;
    assign if4.pwdata  = pwdata;
    assign if2.pstrb   = pstrb;
    assign if4.pstrb   = pstrb;
    assign if2.pprot   = pprot;
    assign if4.pprot   = pprot;

    assign rdata_o = sel ? if4.prdata  : if2.prdata;
    assign rdy_o   = sel ? if4.pready  : if2.pready;
    assign err_o   = sel ? if4.pslverr : if2.pslverr;

    apb_completer_regs #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(2))
        u_dut2 (.pclk(pclk), .preset(preset), .apb(if2));
    apb_completer_regs #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(4))
        u_dut4 (.pclk(pclk), .preset(preset), .apb(if4));

    // Bridge-style transfer; nw counts access-phase cycles until pready (capped at 40).
    task automatic xfer(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                        input logic [3:0] st, input logic [2:0] pr,
                        output logic [31:0] rd, output logic er, output int nw);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a;
        pwdata = wd; pstrb = st; pprot = pr;
        @(posedge pclk); #1;
        penable = 1'b1;
        nw = 0;
        do begin
            @(posedge pclk); #1;
            nw++;
        end while (!rdy_o && nw < 40);
        rd = rdata_o;
        er = err_o;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        preset = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        n_checks++;
        if ({if2.pready, if2.pslverr, if2.prdata, if4.pready, if4.pslverr, if4.prdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy2=%b err2=%b rd2=%h rdy4=%b err4=%b rd4=%h, want all 0",
                     if2.pready, if2.pslverr, if2.prdata, if4.pready, if4.pslverr, if4.prdata);
        end
        preset = 1'b0;
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic er; int nw;
        sel = 1'b0;
        xfer(32'h4, 1'b0, 32'h0, 4'h0, 3'b000, rd, er, nw);
        n_checks++;
        if (rd !== 32'h0 || er !== 1'b0 || nw !== 3) begin
            n_fail++;
            $display("FAIL post_reset_read: got data=%h err=%b waits=%0d, want 00000000 0 3", rd, er, nw);
        end
        xfer(32'h4, 1'b1, 32'hDEADBEEF, 4'hF, 3'b000, rd, er, nw);
        n_checks++;
        if (rd !== 32'h0 || er !== 1'b0 || nw !== 3) begin
            n_fail++;
            $display("FAIL write_resp: got data=%h err=%b waits=%0d, want 00000000 0 3", rd, er, nw);
        end
        n_checks++;
        if (rdy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL pready_one_cycle: got pready=%b, want 0", rdy_o);
        end
        xfer(32'h4, 1'b0, 32'h0, 4'h0, 3'b000, rd, er, nw);
        n_checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0 || nw !== 3) begin
            n_fail++;
            $display("FAIL write_read: got data=%h err=%b waits=%0d, want deadbeef 0 3", rd, er, nw);
        end
    endtask

    task automatic test_partial_strobe();
        logic [31:0] rd; logic er; int nw;
        xfer(32'h4, 1'b1, 32'h11223344, 4'b0101, 3'b000, rd, er, nw);
        xfer(32'h4, 1'b0, 32'h0, 4'h0, 3'b000, rd, er, nw);
        n_checks++;
        if (rd !== 32'hDE22BE44 || er !== 1'b0 || nw !== 3) begin
            n_fail++;
            $display("FAIL partial_strobe: got data=%h err=%b waits=%0d, want de22be44 0 3", rd, er, nw);
        end
    endtask

    task automatic test_protection();
        logic [31:0] rd; logic er; int nw;
        logic [2:0] bad [3];
        bad[0] = 3'b110; bad[1] = 3'b101; bad[2] = 3'b011;
        xfer(32'hE0000004, 1'b0, 32'h0, 4'h0, 3'b111, rd, er, nw);
        n_checks++;
        if (rd !== 32'hDE22BE44 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL prot_ok: got data=%h err=%b, want de22be44 0", rd, er);
        end
        for (int i = 0; i < 3; i++) begin
            xfer(32'hE0000004, 1'b0, 32'h0, 4'h0, bad[i], rd, er, nw);
            n_checks++;
            if (rd !== 32'h0 || er !== 1'b1 || nw !== 3) begin
                n_fail++;
                $display("FAIL prot_read_%b: got data=%h err=%b waits=%0d, want 00000000 1 3",
                         bad[i], rd, er, nw);
            end
        end
        xfer(32'hE0000004, 1'b1, 32'h0, 4'hF, 3'b011, rd, er, nw);
        n_checks++;
        if (er !== 1'b1) begin
            n_fail++;
            $display("FAIL prot_write_err: got err=%b, want 1", er);
        end
        xfer(32'h00000004, 1'b0, 32'h0, 4'h0, 3'b111, rd, er, nw);
        n_checks++;
        if (rd !== 32'hDE22BE44 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL prot_write_blocked: got data=%h err=%b, want de22be44 0", rd, er);
        end
    endtask

    task automatic test_unaligned_range();
        logic [31:0] rd; logic er; int nw;
        xfer(32'h3, 1'b0, 32'h0, 4'h0, 3'b000, rd, er, nw);
        n_checks++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            n_fail++;
            $display("FAIL unaligned_read: got data=%h err=%b, want 00000000 1", rd, er);
        end
        xfer(32'h6, 1'b1, 32'hFFFFFFFF, 4'hF, 3'b000, rd, er, nw);
        n_checks++;
        if (er !== 1'b1) begin
            n_fail++;
            $display("FAIL unaligned_write: got err=%b, want 1", er);
        end
        xfer(32'h40, 1'b0, 32'h0, 4'h0, 3'b000, rd, er, nw);
        n_checks++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            n_fail++;
            $display("FAIL out_of_range: got data=%h err=%b, want 00000000 1", rd, er);
        end
        xfer(32'h3C, 1'b0, 32'h0, 4'h0, 3'b000, rd, er, nw);
        n_checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL last_reg: got data=%h err=%b, want 00000000 0", rd, er);
        end
        xfer(32'h4, 1'b0, 32'h0, 4'h0, 3'b000, rd, er, nw);
        n_checks++;
        if (rd !== 32'hDE22BE44 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL reg1_after_errs: got data=%h err=%b, want de22be44 0", rd, er);
        end
    endtask

    task automatic test_early_psel();
        logic [31:0] rd; logic er; int nw;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h4; pprot = 3'b000;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b1;
        @(posedge pclk); #1;
        n_checks++;
        if (if2.pready !== 1'b1 || if2.pslverr !== 1'b1) begin
            n_fail++;
            $display("FAIL early_psel_resp: got pready=%b err=%b, want 1 1", if2.pready, if2.pslverr);
        end
        penable = 1'b0;
        @(posedge pclk); #1;
        n_checks++;
        if (if2.pready !== 1'b0) begin
            n_fail++;
            $display("FAIL early_psel_one_cycle: got pready=%b, want 0", if2.pready);
        end
        xfer(32'h4, 1'b0, 32'h0, 4'h0, 3'b000, rd, er, nw);
        n_checks++;
        if (rd !== 32'hDE22BE44 || er !== 1'b0 || nw !== 3) begin
            n_fail++;
            $display("FAIL early_psel_recover: got data=%h err=%b waits=%0d, want de22be44 0 3", rd, er, nw);
        end
    endtask

    task automatic test_protocol_errors();
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h4;
        @(posedge pclk); #1;
        n_checks++;
        if (rdy_o !== 1'b1 || err_o !== 1'b1 || rdata_o !== 32'h0) begin
            n_fail++;
            $display("FAIL no_setup: got pready=%b err=%b data=%h, want 1 1 00000000", rdy_o, err_o, rdata_o);
        end
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; paddr = 32'h4;
        @(posedge pclk); #1;
        penable = 1'b1; paddr = 32'h8;
        @(posedge pclk); #1;
        n_checks++;
        if (rdy_o !== 1'b1 || err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL addr_change: got pready=%b err=%b, want 1 1", rdy_o, err_o);
        end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rd; logic er; int nw; int seen;
        sel = 1'b1;
        xfer(32'hC, 1'b1, 32'hA5A5A5A5, 4'hF, 3'b000, rd, er, nw);
        xfer(32'hC, 1'b0, 32'h0, 4'h0, 3'b000, rd, er, nw);
        n_checks++;
        if (rd !== 32'hA5A5A5A5 || er !== 1'b0 || nw !== 5) begin
            n_fail++;
            $display("FAIL ws4_write_read: got data=%h err=%b waits=%0d, want a5a5a5a5 0 5", rd, er, nw);
        end
        seen = 0;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8;
        pwdata = 32'h12345678; pstrb = 4'hF; pprot = 3'b000;
        @(posedge pclk); #1;
        penable = 1'b1;
        repeat (2) begin
            @(posedge pclk); #1;
            if (rdy_o) seen++;
        end
        preset = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b0; psel = 1'b0; penable = 1'b0;
        n_checks++;
        if (if4.pready !== 1'b0 || if4.pslverr !== 1'b0 || if4.prdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got pready=%b err=%b data=%h, want 0 0 00000000",
                     if4.pready, if4.pslverr, if4.prdata);
        end
        repeat (6) begin
            @(posedge pclk); #1;
            if (rdy_o) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_pready: got %0d pready cycles, want 0", seen);
        end
        xfer(32'h8, 1'b0, 32'h0, 4'h0, 3'b000, rd, er, nw);
        n_checks++;
        if (rd !== 32'h0 || er !== 1'b0 || nw !== 5) begin
            n_fail++;
            $display("FAIL reset_mid_read8: got data=%h err=%b waits=%0d, want 00000000 0 5", rd, er, nw);
        end
        xfer(32'hC, 1'b0, 32'h0, 4'h0, 3'b000, rd, er, nw);
        n_checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_readC: got data=%h err=%b, want 00000000 0", rd, er);
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial_strobe();
        test_protection();
        test_unaligned_range();
        test_early_psel();
        test_protocol_errors();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/apb_completer_regs.md
# apb_completer_regs

APB completer (peripheral end of the APB link) that terminates transfers issued by `apb_bridge`. It provides a small byte-strobed register file, a programmable number of wait states, and a protection unit that checks `pprot` against the address region. It reports protocol violations, unaligned accesses, out-of-range accesses and protection faults through `pslverr`. It connects through the completer side of `apb_if`.

## Interface
- `ADDR_WIDTH`, 32, width of `paddr`; must be at least 8.
- `DATA_WIDTH`, 32, width of `pwdata`/`prdata`; fixed at 32.
- `NUM_REGS`, 16, number of 32-bit registers; must be a power of two, 2 to 256.
- `WAIT_STATES`, 0, number of access-phase cycles with `pready` low before completion; range 0 to 15.
- `pclk  in  1  clock`; all logic is clocked on the rising edge.
- `preset  in  1  reset`: synchronous, active-high.
- `psel  in  1`: completer select.
- `penable  in  1`: access phase.
- `pwrite  in  1`: 1 = write, 0 = read.
- `paddr  in  ADDR_WIDTH`: byte address.
- `pwdata  in  DATA_WIDTH`: write data.
- `pstrb  in  DATA_WIDTH/8`: byte write strobes.
- `pprot  in  3`: protection attributes.
- `prdata  out  DATA_WIDTH`: read data; registered.
- `pready  out  1`: transfer complete; registered.
- `pslverr  out  1`: error response; registered.

## Operation
- **Address decode**
  - Region bits are `paddr[ADDR_WIDTH-1:ADDR_WIDTH-3]`, ordered {instruction, non-secure, privileged}. This matches the `apb_pkg` mapping.
  - The register index is `paddr[2 +: log2(NUM_REGS)]`.
  - Register offset is `paddr[ADDR_WIDTH-4:2]`. All regions alias the same registers.
- **FSM states**
  - IDLE
    - On an edge with `psel=1` and `penable=0`: capture `paddr`, `pwrite`, `pwdata`, `pstrb`, `pprot`; load the wait counter with `WAIT_STATES`; go to ACCESS.
    - On an edge with `psel=1` and `penable=1` (access with no setup): go to RESP with error.
    - Any other input: stay in IDLE.
  - ACCESS, evaluated on each edge in this priority order:
    - `psel=0`: early deselect. Go to RESP with error.
    - `paddr` or `pwrite` differs from the captured value: go to RESP with error.
    - `penable=0`: hold.
    - Wait counter is nonzero: decrement it.
    - Otherwise: evaluate the access and go to RESP.
  - RESP
    - `pready=1` for exactly one cycle, then go to IDLE.
    - RESP does not require `psel` or `penable` to still be high.
- **Access evaluation** (error checks in priority order)
  1. `paddr[1:0]!=0`: error.
  2. Offset `>= NUM_REGS`: error.
  3. For each region bit k that is 1, `pprot[k]` must be 1; otherwise error. Extra `pprot` bits set on an unprotected region are allowed.
- **On error:** `pslverr=1`, `prdata=0`, no register is modified.
- **Write without error**
  - For each byte lane i with `pstrb[i]=1`, update that byte of the register.
  - Lanes with `pstrb[i]=0` keep their old value.
  - `prdata=0`.
- **Read without error:** `prdata` = the register contents; `pstrb` is ignored.

## Timing
- **Reset**
  - When `preset=1` at an edge: state goes to IDLE; `pready=0`, `pslverr=0`, `prdata=0`; all registers become 0; wait counter becomes 0.
  - Reset asserted mid-transfer aborts the transfer with no response and no write.
- **Outputs outside RESP:** `pready=0`, `pslverr=0`, `prdata=0`.
- **Latency**
  - Setup is sampled at edge S.
  - `pready` is high during the cycle after edge S+1+`WAIT_STATES`, assuming `penable` is high from S+1 onward.
  - The bridge samples completion at the next edge, S+2+`WAIT_STATES`. It therefore counts `WAIT_STATES+1` loop cycles.
- **Writes** commit at the same edge at which `pready` rises. A read issued immediately afterwards returns the new value.
- **Error paths** (early `psel` drop, no setup, address change): `pready=1` and `pslverr=1` appear one cycle after the edge that detected the violation. They are not delayed by wait states.
- **Back-to-back transfers:** a new setup can be accepted at the edge where RESP returns to IDLE only if that edge shows `psel=1` and `penable=0`. Otherwise the completer waits in IDLE.
- `prdata` and `pslverr` are valid only while `pready=1`.

## Test plan
- **Write then read:** set `WAIT_STATES=2`. Write 0xDEADBEEF to 0x4 with `pstrb`=0xF and `pprot`=000, then read 0x4.
  - Required: `prdata`=0xDEADBEEF and `pslverr`=0.
  - Required: the bridge counts 3 wait cycles on each transfer.
- **Partial strobe:** with 0xDEADBEEF in register 1, write 0x11223344 to 0x4 with `pstrb`=0101, then read 0x4.
  - Required: read returns 0xDE22BE44.
- **Protection:** use address 0xE0000004.
  - Read with `pprot`=111: required `pslverr`=0.
  - Reads with `pprot`=110, 101 and 011: each required `pslverr`=1 and `prdata`=0.
  - Write 0x0 with `pprot`=011: required `pslverr`=1, and register 1 is unchanged.
- **Unaligned and out-of-range:**
  - Read 0x3: required `pslverr`=1.
  - Write 0x6: required `pslverr`=1, register 1 unchanged.
  - Read 0x40 with `NUM_REGS`=16: required `pslverr`=1.
- **Early PSEL deassertion:** complete the setup at 0x4, raise `penable`, and drop `psel` in the same cycle.
  - Required: `pready`=1 and `pslverr`=1 for one cycle after the next edge.
  - Required: a following normal read of 0x4 succeeds.
- **Reset mid-access:** with `WAIT_STATES`=4, assert `preset` for one edge during the wait of a write of 0x12345678 to 0x8.
  - Required: `pready` never rises for that write.
  - Required: all outputs are 0, and a later read of 0x8 returns 0x00000000.
